// File: rtl/ren_conv_seq.sv
// Wishbone master sequencer for the convolver slave. Runs one job per
// accepted command: image load, kernel load, config writes, start, done
// polling, and result read-back onto an 8-bit valid/ready stream.
module ren_conv_seq #(
    parameter logic [7:0] SLV_ADDR  = 8'h30,
    parameter int         CNT_WIDTH = 6,
    parameter int         DONE_BIT  = 0,
    parameter int         POLL_GAP  = 4,
    parameter int         TIMEOUT   = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CNT_WIDTH-1:0] img_words,
    input  logic [CNT_WIDTH-1:0] kern_words,
    input  logic [CNT_WIDTH-1:0] rslt_words,
    input  logic [31:0]          cfg1_i,
    input  logic [31:0]          cfg2_i,
    input  logic [31:0]          cfg3_i,
    input  logic [31:0]          start_word_i,
    input  logic                 s_valid,
    input  logic [23:0]          s_data,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [7:0]           m_data,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 err,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic [31:0]          wbm_dat_i,
    input  logic                 wbm_ack_i
);

    localparam int GW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {
        IDLE, LD_IMG, LD_KERN, CFG, START, POLL, RD_RES
    } state_t;

    state_t               state_q;
    logic                 cyc_q, we_q, s_ready_q, m_valid_q, err_q;
    logic [31:0]          adr_q, dat_q;
    logic [7:0]           m_data_q;
    logic [7:0]           to_q;
    logic [GW-1:0]        gap_q;
    logic [CNT_WIDTH-1:0] idx_q, img_n_q, kern_n_q, rslt_n_q;
    logic [31:0]          cfg1_q, cfg2_q, cfg3_q, start_q;

    logic [CNT_WIDTH-1:0] idx_d;
    logic [31:0]          cfg_word_d;
    logic                 unused_dat;

    // Bus address: slave select, region (0 regs, 1 img, 2 kern, 3 result), word index.
    function automatic logic [31:0] bus_adr(input logic [1:0] rg, input logic [CNT_WIDTH-1:0] ix);
        return {SLV_ADDR, 14'h0, rg, ix, 2'b00};
    endfunction

    // Next index and the config value for the register currently being written.
    always_comb begin
        idx_d      = idx_q + 1'b1;
        cfg_word_d = cfg3_q;
        case (idx_q[1:0])
            2'd0:    cfg_word_d = cfg1_q;
            2'd1:    cfg_word_d = cfg2_q;
            default: cfg_word_d = cfg3_q;
        endcase
    end

    // Job FSM and bus master; one bus cycle at a time, always an idle cycle between them.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            m_data_q  <= '0;
            to_q      <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            img_n_q   <= '0;
            kern_n_q  <= '0;
            rslt_n_q  <= '0;
            cfg1_q    <= '0;
            cfg2_q    <= '0;
            cfg3_q    <= '0;
            start_q   <= '0;
        end else if (cyc_q) begin
            if (wbm_ack_i) begin
                cyc_q <= 1'b0;
                to_q  <= '0;
                case (state_q)
                    LD_IMG: begin
                        if (idx_q == img_n_q) begin
                            idx_q   <= '0;
                            state_q <= LD_KERN;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                    LD_KERN: begin
                        if (idx_q == kern_n_q) begin
                            idx_q   <= '0;
                            state_q <= CFG;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                    CFG: begin
                        if (idx_q == CNT_WIDTH'(2)) begin
                            idx_q   <= '0;
                            state_q <= START;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                    START: begin
                        gap_q   <= '0;
                        state_q <= POLL;
                    end
                    POLL: begin
                        gap_q <= '0;
                        if (wbm_dat_i[DONE_BIT]) begin
                            idx_q   <= '0;
                            state_q <= RD_RES;
                        end
                    end
                    RD_RES: begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= wbm_dat_i[7:0];
                    end
                    default: ;
                endcase
            end else if (to_q == 8'(TIMEOUT - 1)) begin
                // Slave is unresponsive: abandon the job and flag it.
                cyc_q     <= 1'b0;
                to_q      <= '0;
                err_q     <= 1'b1;
                m_valid_q <= 1'b0;
                s_ready_q <= 1'b0;
                state_q   <= IDLE;
            end else begin
                to_q <= to_q + 8'd1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        img_n_q  <= img_words;
                        kern_n_q <= kern_words;
                        rslt_n_q <= rslt_words;
                        cfg1_q   <= cfg1_i;
                        cfg2_q   <= cfg2_i;
                        cfg3_q   <= cfg3_i;
                        start_q  <= start_word_i;
                        err_q    <= 1'b0;
                        idx_q    <= '0;
                        state_q  <= LD_IMG;
                    end
                end
                LD_IMG, LD_KERN: begin
                    if (!s_ready_q) begin
                        s_ready_q <= 1'b1;
                    end else if (s_valid) begin
                        s_ready_q <= 1'b0;
                        cyc_q     <= 1'b1;
                        we_q      <= 1'b1;
                        adr_q     <= bus_adr((state_q == LD_IMG) ? 2'd1 : 2'd2, idx_q);
                        dat_q     <= {8'h0, s_data};
                    end
                end
                CFG: begin
                    cyc_q <= 1'b1;
                    we_q  <= 1'b1;
                    adr_q <= bus_adr(2'd0, idx_d);
                    dat_q <= cfg_word_d;
                end
                START: begin
                    cyc_q <= 1'b1;
                    we_q  <= 1'b1;
                    adr_q <= bus_adr(2'd0, '0);
                    dat_q <= start_q;
                end
                POLL: begin
                    if (gap_q == GW'(POLL_GAP)) begin
                        gap_q <= '0;
                        cyc_q <= 1'b1;
                        we_q  <= 1'b0;
                        adr_q <= bus_adr(2'd0, '0);
                        dat_q <= '0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                RD_RES: begin
                    // Next result read waits until the held byte has been taken.
                    if (m_valid_q) begin
                        if (m_ready) begin
                            m_valid_q <= 1'b0;
                            if (idx_q == rslt_n_q) state_q <= IDLE;
                            else                   idx_q   <= idx_d;
                        end
                    end else begin
                        cyc_q <= 1'b1;
                        we_q  <= 1'b0;
                        adr_q <= bus_adr(2'd3, idx_q);
                        dat_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Only the done bit and the low result byte of read data matter.
    assign unused_dat = ^wbm_dat_i;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = 4'hF;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_ren_conv_seq.sv
// Bench for ren_conv_seq: wishbone slave model, result consumer, and a
// scoreboard of expected bus transactions and result bytes.
module tb_ren_conv_seq;

    logic        wb_clk_i, wb_rst_i;
    logic        cmd_valid, cmd_ready;
    logic [5:0]  img_words, kern_words, rslt_words;
    logic [31:0] cfg1_i, cfg2_i, cfg3_i, start_word_i;
    logic        s_valid, s_ready;
    logic [23:0] s_data;
    logic        m_valid, m_ready;
    logic [7:0]  m_data;
    logic        busy, err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;

    ren_conv_seq dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .img_words(img_words), .kern_words(kern_words), .rslt_words(rslt_words),
        .cfg1_i(cfg1_i), .cfg2_i(cfg2_i), .cfg3_i(cfg3_i), .start_word_i(start_word_i),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .err(err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] exp_m[$];

    int checks = 0, failures = 0;
    int ack_dly = 0, no_ack = 0, done_after = 1, poll_cnt = 0, stall = 0;
    int hs_cnt = 0, cyc_hi = 0, idle_cnt = 0, last_idle = 0;
    logic prev_cyc = 1'b0;

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] A(input logic [1:0] rg, input int ix);
        logic [5:0] i6;
        i6 = ix[5:0];
        return {8'h30, 14'h0, rg, i6, 2'b00};
    endfunction

    function automatic logic [31:0] res_word(input logic [5:0] ix);
        logic [7:0] b;
        b = 8'(ix * 37 + 11);
        return {16'hC0DE, 8'h5A, b};
    endfunction

    function automatic logic [23:0] img_word(input int i);
        return 24'(i * 3);
    endfunction

    function automatic logic [23:0] kern_word(input int i);
        return 24'hA50000 + 24'(i * 5);
    endfunction

    // Wishbone slave: acks after ack_dly extra cycles and checks each transaction.
    initial begin : slave
        bus_t e;
        int   wcnt;
        logic [5:0] ix;
        wcnt = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(negedge wb_clk_i);
            if (wbm_cyc_o) cyc_hi++;
            if (wbm_cyc_o && !prev_cyc) begin
                last_idle = idle_cnt;
                idle_cnt  = 0;
            end
            if (!wbm_cyc_o) idle_cnt++;
            prev_cyc = wbm_cyc_o;
            if (wbm_ack_i) begin
                wbm_ack_i = 1'b0;
            end else if (wbm_cyc_o && wbm_stb_o && no_ack == 0) begin
                if (wcnt < ack_dly) begin
                    wcnt++;
                end else begin
                    wcnt = 0;
                    wbm_ack_i = 1'b1;
                    checks++;
                    assert (bus_q.size() > 0) else begin
                        failures++;
                        $error("FAIL bus_unexpected observed adr=%h expected no cycle", wbm_adr_o);
                    end
                    if (bus_q.size() > 0) begin
                        e = bus_q.pop_front();
                        chk("bus_adr", wbm_adr_o, e.adr);
                        chk("bus_we", {31'h0, wbm_we_o}, {31'h0, e.we});
                        if (e.we) chk("bus_dat", wbm_dat_o, e.dat);
                    end
                    chk("bus_sel", {28'h0, wbm_sel_o}, 32'hF);
                    chk("bus_stb", {31'h0, wbm_stb_o}, 32'h1);
                    chk("bus_idle_gap", {31'h0, last_idle >= 1}, 32'h1);
                    ix = wbm_adr_o[7:2];
                    if (!wbm_we_o && wbm_adr_o == 32'h30000000) begin
                        poll_cnt++;
                        chk("poll_gap", {31'h0, last_idle >= 4}, 32'h1);
                        wbm_dat_i = {31'h2D2D2D2D, poll_cnt >= done_after};
                    end else if (!wbm_we_o) begin
                        chk("rd_before_take", {31'h0, m_valid}, 32'h0);
                        wbm_dat_i = res_word(ix);
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Result consumer: stalls `stall` cycles per byte, checks hold and order.
    initial begin : consumer
        int scnt;
        logic [7:0] held, ex;
        scnt = 0;
        held = '0;
        m_ready = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (!wb_rst_i) begin
                m_ready = 1'b0;
                scnt = 0;
            end else if (m_ready) begin
                m_ready = 1'b0;
                scnt = 0;
            end else if (m_valid) begin
                if (scnt > 0) chk("m_hold", {24'h0, m_data}, {24'h0, held});
                held = m_data;
                if (scnt >= stall) begin
                    checks++;
                    assert (exp_m.size() > 0) else begin
                        failures++;
                        $error("FAIL m_unexpected observed=%h expected no byte", m_data);
                    end
                    if (exp_m.size() > 0) begin
                        ex = exp_m.pop_front();
                        chk("m_data", {24'h0, m_data}, {24'h0, ex});
                    end
                    m_ready = 1'b1;
                end else begin
                    scnt++;
                end
            end
        end
    end

    // Input handshake monitor; s_ready must never coexist with an open bus cycle.
    initial begin : s_mon
        forever begin
            @(negedge wb_clk_i);
            if (s_ready && s_valid) hs_cnt++;
            if (s_ready) chk("s_ready_bus_open", {31'h0, wbm_cyc_o}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic send_word(input logic [23:0] w);
        bit got;
        got = 0;
        s_data  = w;
        s_valid = 1'b1;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge wb_clk_i);
            if (s_ready) begin
                got = 1;
                @(posedge wb_clk_i);
                #1;
            end
        end
        s_valid = 1'b0;
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL s_ready_timeout observed=no handshake expected=handshake");
        end
    endtask

    task automatic send_cmd(input int ni, input int nk, input int nr);
        img_words    = 6'(ni);
        kern_words   = 6'(nk);
        rslt_words   = 6'(nr);
        cfg1_i       = $urandom;
        cfg2_i       = $urandom;
        cfg3_i       = $urandom;
        start_word_i = $urandom | 32'h1;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid    = 1'b0;
        chk("busy_after_cmd", {31'h0, busy}, 32'h1);
        chk("cmd_ready_busy", {31'h0, cmd_ready}, 32'h0);
        chk("err_cleared", {31'h0, err}, 32'h0);
    endtask

    // Push the full expected job, issue the command, stream all words.
    task automatic start_job(input int ni, input int nk, input int nr, input int da, input int st);
        done_after = da;
        poll_cnt   = 0;
        stall      = st;
        send_cmd(ni, nk, nr);
        for (int i = 0; i <= ni; i++) bus_q.push_back('{adr: A(2'd1, i), we: 1'b1, dat: {8'h0, img_word(i)}});
        for (int i = 0; i <= nk; i++) bus_q.push_back('{adr: A(2'd2, i), we: 1'b1, dat: {8'h0, kern_word(i)}});
        bus_q.push_back('{adr: A(2'd0, 1), we: 1'b1, dat: cfg1_i});
        bus_q.push_back('{adr: A(2'd0, 2), we: 1'b1, dat: cfg2_i});
        bus_q.push_back('{adr: A(2'd0, 3), we: 1'b1, dat: cfg3_i});
        bus_q.push_back('{adr: A(2'd0, 0), we: 1'b1, dat: start_word_i});
        for (int i = 0; i < da; i++) bus_q.push_back('{adr: A(2'd0, 0), we: 1'b0, dat: 32'h0});
        for (int i = 0; i <= nr; i++) begin
            bus_q.push_back('{adr: A(2'd3, i), we: 1'b0, dat: 32'h0});
            exp_m.push_back(res_word(6'(i)) & 32'hFF);
        end
        for (int i = 0; i <= ni; i++) send_word(img_word(i));
        for (int i = 0; i <= nk; i++) send_word(kern_word(i));
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 5000; k++) begin
            if (!busy && bus_q.size() == 0 && exp_m.size() == 0) break;
            tick();
        end
        chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
        chk({tag, "_bus_left"}, bus_q.size(), 32'h0);
        chk({tag, "_m_left"}, exp_m.size(), 32'h0);
        chk({tag, "_polls"}, poll_cnt, done_after);
        chk({tag, "_err"}, {31'h0, err}, 32'h0);
    endtask

    initial begin : main
        wb_rst_i   = 1'b0;
        cmd_valid  = 1'b0;
        img_words  = '0;
        kern_words = '0;
        rslt_words = '0;
        cfg1_i = '0; cfg2_i = '0; cfg3_i = '0; start_word_i = '0;
        s_valid = 1'b0;
        s_data  = '0;
        #1;
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
        chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        tick();

        // Minimal job; extra input words must not be accepted.
        hs_cnt = 0;
        start_job(0, 0, 0, 1, 0);
        s_data  = 24'hFFFFFF;
        s_valid = 1'b1;
        wait_done("min");
        s_valid = 1'b0;
        chk("min_hs", hs_cnt, 32'd2);

        // Full 64-word image load.
        hs_cnt = 0;
        start_job(63, 1, 0, 1, 0);
        wait_done("full");
        chk("full_hs", hs_cnt, 32'd66);

        // Done on fifth poll, slower slave.
        ack_dly = 2;
        start_job(1, 0, 0, 5, 0);
        wait_done("poll");
        ack_dly = 0;

        // Backpressure on result stream.
        start_job(2, 1, 3, 1, 10);
        wait_done("bp");

        // Timeout on first image write.
        no_ack = 1;
        send_cmd(0, 0, 0);
        cyc_hi = 0;
        send_word(24'h123456);
        for (int k = 0; k < 400 && !err; k++) tick();
        chk("to_err", {31'h0, err}, 32'h1);
        chk("to_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        chk("to_idle", {31'h0, cmd_ready}, 32'h1);
        chk("to_cyc_len", cyc_hi, 32'd255);
        no_ack = 0;
        repeat (3) tick();
        chk("to_err_sticky", {31'h0, err}, 32'h1);
        chk("to_no_resume", {31'h0, wbm_cyc_o}, 32'h0);
        start_job(0, 1, 1, 2, 0);
        wait_done("after_to");

        // Async reset while a result byte is held.
        start_job(0, 0, 2, 1, 200);
        for (int k = 0; k < 500 && !m_valid; k++) tick();
        chk("rr_m_valid_before", {31'h0, m_valid}, 32'h1);
        #1;
        wb_rst_i = 1'b0;
        #1;
        chk("rr_m_valid", {31'h0, m_valid}, 32'h0);
        chk("rr_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        chk("rr_busy", {31'h0, busy}, 32'h0);
        bus_q.delete();
        exp_m.delete();
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        tick();
        chk("rr_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        repeat (5) tick();
        chk("rr_no_resume", {31'h0, wbm_cyc_o}, 32'h0);
        chk("rr_m_valid_after", {31'h0, m_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
